// File: rtl/arb_mux_reg.sv
// rtl/arb_mux_reg.sv - arbitrated N-to-1 mux with one-entry registered output and valid/ready handshake
// Round-robin or fixed-priority grant; the granted word lands in the output register on the same edge.
module arb_mux_reg #(
  parameter int WIDTH         = 32,
  parameter int MUX_QUANTITY  = 4,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [MUX_QUANTITY-1:0]       in_valid,
  input  logic [WIDTH*MUX_QUANTITY-1:0] in_data,
  output logic [MUX_QUANTITY-1:0]       in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [MUX_QUANTITY-1:0]       out_sel
);

  localparam int PW = (MUX_QUANTITY > 1) ? $clog2(MUX_QUANTITY) : 1;

  logic [PW-1:0]           r_ptr;
  logic                    r_out_valid;
  logic [WIDTH-1:0]        r_out_data;
  logic [MUX_QUANTITY-1:0] r_out_sel;

  logic                    w_load;
  logic                    w_found;
  logic [PW-1:0]           w_idx;
  logic [PW-1:0]           w_cand;
  logic                    w_take;
  logic [MUX_QUANTITY-1:0] w_grant;
  int                      w_pos;

  assign w_load = !r_out_valid || out_ready;

  // Search from r_ptr (or from 0 in fixed-priority mode); first valid channel wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    w_pos   = 0;
    for (int k = 0; k < MUX_QUANTITY; k++) begin
      if (PRIORITY_MODE != 0) w_pos = k;
      else                    w_pos = (int'(r_ptr) + k) % MUX_QUANTITY;
      w_cand = PW'(w_pos);
      if (!w_found && in_valid[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  // rst_n gates the grant so no handshake can complete while reset is held.
  assign w_take = w_load && w_found && rst_n;

  always_comb begin
    w_grant = '0;
    if (w_take) w_grant[w_idx] = 1'b1;
  end

  assign in_ready = w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_take) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[int'(w_idx)*WIDTH +: WIDTH];
      r_out_sel   <= w_grant;
      if (PRIORITY_MODE == 0) begin
        if (int'(w_idx) == MUX_QUANTITY - 1) r_ptr <= '0;
        else                                 r_ptr <= w_idx + PW'(1);
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux_reg.sv
// tb/tb_arb_mux_reg.sv - scoreboard bench for arb_mux_reg, round-robin and fixed-priority instances
// Stimulus pushes expected {sel,data}; negedge monitors pop whenever an output word is consumed.
module tb_arb_mux_reg;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [W*N-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [N-1:0]   out_sel;

  logic [N-1:0]   fp_in_valid;
  logic [N-1:0]   fp_in_ready;
  logic           fp_out_valid;
  logic           fp_out_ready;
  logic [W-1:0]   fp_out_data;
  logic [N-1:0]   fp_out_sel;

  logic [N+W-1:0] sb_rr[$];
  logic [N+W-1:0] sb_fp[$];
  logic [N+W-1:0] exp_w;

  int n_checks;
  int n_errors;

  arb_mux_reg #(.WIDTH(W), .MUX_QUANTITY(N), .PRIORITY_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  arb_mux_reg #(.WIDTH(W), .MUX_QUANTITY(N), .PRIORITY_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(fp_in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_ready(fp_out_ready),
    .out_data(fp_out_data), .out_sel(fp_out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N+W-1:0] word(input int ch);
    logic [N-1:0] s;
    s = '0;
    s[ch] = 1'b1;
    return {s, W'(32'hA0 + ch)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb_rr.size() == 0) check("rr_unexpected_output", {28'd0, out_sel, out_data}, 64'd0);
      else begin
        exp_w = sb_rr.pop_front();
        check("rr_output", {28'd0, out_sel, out_data}, {28'd0, exp_w});
      end
    end
    if (fp_out_valid && fp_out_ready) begin
      if (sb_fp.size() == 0) check("fp_unexpected_output", {28'd0, fp_out_sel, fp_out_data}, 64'd0);
      else begin
        exp_w = sb_fp.pop_front();
        check("fp_output", {28'd0, fp_out_sel, fp_out_data}, {28'd0, exp_w});
      end
    end
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b1;
    in_valid     = 4'b1111;
    out_ready    = 1'b0;
    fp_in_valid  = 4'b0000;
    fp_out_ready = 1'b1;
    in_data      = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    #1 rst_n = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data",  64'(out_data),  64'd0);
    check("reset_out_sel",   64'(out_sel),   64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd0);
    repeat (2) step();

    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb_rr.push_back(word(i % N));
      step();
    end

    in_valid = 4'b0010;
    sb_rr.push_back(word(1));
    step();
    in_valid = 4'b1001;
    #1 check("skip_ready_ch3", 64'(in_ready), 64'b1000);
    sb_rr.push_back(word(3));
    step();
    check("skip_ready_ch0", 64'(in_ready), 64'b0001);
    sb_rr.push_back(word(0));
    step();

    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 64'(in_ready),  64'd0);
      check("stall_out_data", 64'(out_data),  64'hA0);
      check("stall_out_sel",  64'(out_sel),   64'b0001);
      step();
    end
    out_ready = 1'b1;
    #1 check("release_ready_ch1", 64'(in_ready), 64'b0010);
    sb_rr.push_back(word(1));
    step();
    check("release_out_valid", 64'(out_valid), 64'd1);

    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_out_data",  64'(out_data),  64'd0);
    check("midreset_in_ready",  64'(in_ready),  64'd0);
    sb_rr.delete();
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1 check("post_reset_ready_ch0", 64'(in_ready), 64'b0001);
    sb_rr.push_back(word(0));
    step();
    sb_rr.push_back(word(1));
    step();
    in_valid = 4'b0000;
    step();
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_out_data",  64'(out_data),  64'hA1);
    check("drain_out_sel",   64'(out_sel),   64'b0010);

    fp_in_valid = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      #1 check("fp_ready_ch1", 64'(fp_in_ready), 64'b0010);
      sb_fp.push_back(word(1));
      step();
    end
    fp_in_valid = 4'b1100;
    #1 check("fp_ready_ch2", 64'(fp_in_ready), 64'b0100);
    sb_fp.push_back(word(2));
    step();
    fp_in_valid = 4'b0000;
    repeat (3) step();

    check("rr_scoreboard_empty", 64'(sb_rr.size()), 64'd0);
    check("fp_scoreboard_empty", 64'(sb_fp.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
